// File: rtl/lsu_axi_fsm.sv
// Sequential load/store unit: one core request at a time, run as an AXI4-Lite transaction.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned requests into err=2 with no bus traffic.

module lsu_axi_lane #(
   parameter int LANE   = 0,
   parameter int NBYTES = 4,
   parameter int OFFW   = 2
) (
   input  logic [OFFW-1:0]        off,
   input  logic [1:0]             size,
   input  logic [NBYTES-1:0][7:0] src,
   output logic [7:0]             lane_byte,
   output logic                   lane_strb
);
   logic [OFFW-1:0] idx;

   // Lane LANE carries source byte LANE-off; lanes below the offset stay empty.
   always_comb begin
      idx       = OFFW'(LANE) - off;
      lane_byte = 8'h00;
      lane_strb = 1'b0;
      if (int'(off) <= LANE) begin
         lane_byte = src[idx];
         lane_strb = int'(idx) < (1 << size);
      end
   end
endmodule

module lsu_axi_fsm #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_funct,
   input  logic [1:0]           req_size,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [XLEN-1:0]      req_wdata,
   output logic                 resp_valid,
   output logic [XLEN-1:0]      resp_rdata,
   output logic [1:0]           resp_err,
   output logic [ADDR_W-1:0]    awaddr,
   output logic                 awvalid,
   input  logic                 awready,
   output logic [XLEN-1:0]      wdata,
   output logic [XLEN/8-1:0]    wstrb,
   output logic                 wvalid,
   input  logic                 wready,
   input  logic [1:0]           bresp,
   input  logic                 bvalid,
   output logic                 bready,
   output logic [ADDR_W-1:0]    araddr,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic [XLEN-1:0]      rdata,
   input  logic [1:0]           rresp,
   input  logic                 rvalid,
   output logic                 rready
);
   localparam int NBYTES = XLEN / 8;
   localparam int OFFW   = $clog2(NBYTES);

   localparam logic [1:0] F_NONE = 2'd0;
   localparam logic [1:0] F_LD   = 2'd1;

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_t;

   typedef struct packed {
      logic [1:0]      funct;
      logic [1:0]      size;
      logic [OFFW-1:0] off;
   } req_t;

   state_t                   state, state_nx;
   req_t                     req_q;
   logic [ADDR_W-1:0]        addr_q;
   logic [XLEN-1:0]          wdata_q, rdata_q;
   logic [NBYTES-1:0]        wstrb_q;
   logic [1:0]               err_q, early_err;
   logic                     aw_done, w_done;
   logic [NBYTES-1:0][7:0]   wlane;
   logic [NBYTES-1:0]        wstrb_nx;
   logic [XLEN-1:0]          ld_shift, ld_ext;
   logic                     ld_sign;
   int                       ld_bits;

   // Requests that end without any bus traffic.
   always_comb begin
      early_err = 2'd0;
      if (req_size == 2'd3 && XLEN == 32) early_err = 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
      else if ((req_addr[OFFW-1:0] & OFFW'((1 << req_size) - 1)) != '0) early_err = 2'd2;
`endif
   end

   genvar g;
   for (g = 0; g < NBYTES; g++) begin : g_lane
      lsu_axi_lane #(.LANE(g), .NBYTES(NBYTES), .OFFW(OFFW)) u_lane (
         .off       (req_addr[OFFW-1:0]),
         .size      (req_size),
         .src       (req_wdata),
         .lane_byte (wlane[g]),
         .lane_strb (wstrb_nx[g])
      );
   end

   // Bytes shifted past the top lane come in as zero before extension.
   always_comb begin
      ld_shift = rdata >> {req_q.off, 3'b000};
      case (req_q.size)
         2'd0:    ld_sign = ld_shift[7];
         2'd1:    ld_sign = ld_shift[15];
         2'd2:    ld_sign = ld_shift[31];
         default: ld_sign = ld_shift[XLEN-1];
      endcase
      ld_sign = ld_sign & (req_q.funct == F_LD);
      ld_bits = 8 << req_q.size;
      ld_ext  = ld_shift;
      for (int i = 0; i < XLEN; i++)
         if (i >= ld_bits) ld_ext[i] = ld_sign;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (req_valid && req_funct != F_NONE) begin
               if (early_err != 2'd0)      state_nx = RESP;
               else if (req_funct == 2'd3) state_nx = WR_AW;
               else                        state_nx = RD_A;
            end
         RD_A:  if (arready) state_nx = RD_D;
         RD_D:  if (rvalid)  state_nx = RESP;
         WR_AW: if ((aw_done || awready) && (w_done || wready)) state_nx = WR_B;
         WR_B:  if (bvalid)  state_nx = RESP;
         RESP:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      arvalid    = (state == RD_A);
      rready     = (state == RD_D);
      awvalid    = (state == WR_AW) && !aw_done;
      wvalid     = (state == WR_AW) && !w_done;
      bready     = (state == WR_B);
      resp_valid = (state == RESP);
   end

   assign araddr     = addr_q;
   assign awaddr     = addr_q;
   assign wdata      = wdata_q;
   assign wstrb      = wstrb_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 2'd0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (req_valid && req_funct != F_NONE) begin
                  req_q.funct <= req_funct;
                  req_q.size  <= req_size;
                  req_q.off   <= req_addr[OFFW-1:0];
                  addr_q      <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                  wdata_q     <= wlane;
                  wstrb_q     <= wstrb_nx;
                  rdata_q     <= '0;
                  err_q       <= early_err;
                  aw_done     <= 1'b0;
                  w_done      <= 1'b0;
               end
            WR_AW: begin
               if (awready) aw_done <= 1'b1;
               if (wready)  w_done  <= 1'b1;
            end
            RD_D:
               if (rvalid) begin
                  rdata_q <= (rresp != 2'd0) ? '0 : ld_ext;
                  err_q   <= (rresp != 2'd0) ? 2'd1 : 2'd0;
               end
            WR_B:
               if (bvalid) begin
                  rdata_q <= '0;
                  err_q   <= (bresp != 2'd0) ? 2'd1 : 2'd0;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_axi_fsm.sv
// Randomized + directed bench for lsu_axi_fsm with an AXI4-Lite slave model and byte-level reference.
module tb_lsu_axi_fsm;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;
   localparam int NBYTES = XLEN / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              req_valid, req_ready, resp_valid;
   logic [1:0]        req_funct, req_size, resp_err;
   logic [ADDR_W-1:0] req_addr, awaddr, araddr;
   logic [XLEN-1:0]   req_wdata, resp_rdata, wdata, rdata;
   logic [NBYTES-1:0] wstrb;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [1:0]        bresp, rresp;

   lsu_axi_fsm #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   int n_chk = 0;
   int n_fail = 0;

   // slave behaviour for the next transaction
   int              ar_dly, aw_dly, w_dly, r_dly, b_dly;
   logic [XLEN-1:0] s_rdata;
   logic [1:0]      s_xresp;

   // observations of the last transaction
   logic              o_ar, o_aw;
   logic [ADDR_W-1:0] o_araddr, o_awaddr;
   logic [XLEN-1:0]   o_wdata, o_rdata;
   logic [NBYTES-1:0] o_wstrb;
   logic [1:0]        o_err;
   int                o_lat, o_nresp, o_viol;

   // expected results of the last modelled request
   int                e_bus;  // 0 none, 1 read, 2 write
   logic [XLEN-1:0]   e_rdata, e_wdata;
   logic [1:0]        e_err;
   logic [ADDR_W-1:0] e_baddr;
   logic [NBYTES-1:0] e_wstrb;

   task automatic model(input logic [1:0] f, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                        input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rd, input logic [1:0] xr);
      int nb, off;
      logic [XLEN-1:0] v;
      nb = 1 << sz;
      off = int'(a % NBYTES);
      e_baddr = a - ADDR_W'(off);
      e_bus = 0; e_rdata = '0; e_err = 2'd0; e_wstrb = '0;
      e_wdata = wd << (8 * off);
      if (f == 2'd0) return;
      if (nb > NBYTES) e_err = 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
      else if (off % nb != 0) e_err = 2'd2;
`endif
      else if (f == 2'd3) begin
         e_bus = 2;
         for (int k = 0; k < nb; k++) if (off + k < NBYTES) e_wstrb[off + k] = 1'b1;
         e_err = (xr != 2'd0) ? 2'd1 : 2'd0;
      end else begin
         e_bus = 1;
         v = '0;
         for (int k = 0; k < nb; k++)
            if (off + k < NBYTES) v[8*k +: 8] = rd[8*(off+k) +: 8];
         if (f == 2'd1 && 8 * nb < XLEN && v[8*nb-1])
            for (int i = 8 * nb; i < XLEN; i++) v[i] = 1'b1;
         if (xr != 2'd0) e_err = 2'd1;
         else e_rdata = v;
      end
   endtask

   task automatic slave_idle();
      awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
      rdata = '0; rresp = 2'd0; bresp = 2'd0;
   endtask

   // Issue one request and play the slave; records observations only.
   task automatic do_txn(input logic [1:0] f, input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                         input logic [XLEN-1:0] wd);
      int cyc, post, arc, awc, wc, rc, bc;
      logic ar_hs, aw_hs, w_hs, r_hs, b_hs, ar_dn, aw_dn, w_dn, r_dn, b_dn;
      logic p_ar, p_aw, p_w;
      logic [ADDR_W-1:0] p_araddr, p_awaddr;
      logic [XLEN-1:0] p_wdata;
      logic [NBYTES-1:0] p_wstrb;
      o_ar = 0; o_aw = 0; o_araddr = '0; o_awaddr = '0; o_wdata = '0; o_wstrb = '0;
      o_rdata = '0; o_err = 2'd0; o_lat = -1; o_nresp = 0; o_viol = 0;
      arc = 0; awc = 0; wc = 0; rc = 0; bc = 0;
      ar_dn = 0; aw_dn = 0; w_dn = 0; r_dn = 0; b_dn = 0;
      p_ar = 0; p_aw = 0; p_w = 0; p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
      req_valid = 1; req_funct = f; req_size = sz; req_addr = a; req_wdata = wd;
      cyc = 0;
      while (!req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      req_valid = 0; req_funct = 2'($urandom); req_addr = $urandom;
      cyc = 1; post = 0;
      while (cyc < 40 && post < 4) begin
         if (resp_valid) begin
            o_nresp++;
            if (o_nresp == 1) begin o_lat = cyc; o_rdata = resp_rdata; o_err = resp_err; end
         end
         if (o_nresp > 0) post++;
         if (p_ar && (!arvalid || araddr !== p_araddr)) o_viol++;
         if (p_aw && (!awvalid || awaddr !== p_awaddr)) o_viol++;
         if (p_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) o_viol++;
         if (arvalid && !o_ar) begin o_ar = 1; o_araddr = araddr; end
         if (awvalid && !o_aw) begin o_aw = 1; o_awaddr = awaddr; o_wdata = wdata; o_wstrb = wstrb; end
         arready = arvalid && (arc >= ar_dly); if (arvalid) arc++;
         awready = awvalid && (awc >= aw_dly); if (awvalid) awc++;
         wready  = wvalid && (wc >= w_dly);    if (wvalid) wc++;
         rvalid = ar_dn && !r_dn && (rc >= r_dly); if (ar_dn && !r_dn) rc++;
         rdata = rvalid ? s_rdata : XLEN'($urandom);
         rresp = rvalid ? s_xresp : 2'd0;
         bvalid = aw_dn && w_dn && !b_dn && (bc >= b_dly); if (aw_dn && w_dn && !b_dn) bc++;
         bresp = bvalid ? s_xresp : 2'd0;
         ar_hs = arvalid && arready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
         r_hs = rvalid && rready;    b_hs = bvalid && bready;
         p_ar = arvalid && !ar_hs; p_araddr = araddr;
         p_aw = awvalid && !aw_hs; p_awaddr = awaddr;
         p_w = wvalid && !w_hs; p_wdata = wdata; p_wstrb = wstrb;
         @(posedge clk); #1;
         ar_dn |= ar_hs; aw_dn |= aw_hs; w_dn |= w_hs; r_dn |= r_hs; b_dn |= b_hs;
         cyc++;
      end
      slave_idle();
   endtask

   task automatic set_slave(input int ar, input int aw, input int w, input int r, input int b,
                            input logic [XLEN-1:0] rd, input logic [1:0] xr);
      ar_dly = ar; aw_dly = aw; w_dly = w; r_dly = r; b_dly = b; s_rdata = rd; s_xresp = xr;
   endtask

   task automatic test_reset();
      n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      n_chk++; if ({resp_valid, awvalid, wvalid, arvalid, bready, rready} !== 6'b0) begin n_fail++;
         $display("FAIL reset_valids got %b exp 000000", {resp_valid, awvalid, wvalid, arvalid, bready, rready}); end
      n_chk++; if ({resp_rdata, resp_err, araddr, awaddr, wdata, wstrb} !== '0) begin n_fail++;
         $display("FAIL reset_payload rdata=%h err=%h araddr=%h awaddr=%h wdata=%h wstrb=%h exp all 0",
                  resp_rdata, resp_err, araddr, awaddr, wdata, wstrb); end
   endtask

   task automatic test_ld_byte_sign();
      set_slave(0, 0, 0, 0, 0, 32'h80FF_0000, 2'd0);
      do_txn(2'd1, 2'd0, 32'h1003, '0);
      n_chk++; if (o_araddr !== 32'h1000) begin n_fail++; $display("FAIL ldb_araddr got %h exp 00001000", o_araddr); end
      n_chk++; if (o_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL ldb_rdata got %h exp ffffff80", o_rdata); end
      n_chk++; if (o_err !== 2'd0) begin n_fail++; $display("FAIL ldb_err got %0d exp 0", o_err); end
      n_chk++; if (o_lat !== 3) begin n_fail++; $display("FAIL ldb_latency got %0d exp 3", o_lat); end
      n_chk++; if (o_nresp !== 1 || o_aw !== 1'b0) begin n_fail++; $display("FAIL ldb_resp_count got %0d aw=%b exp 1 aw=0", o_nresp, o_aw); end
   endtask

   task automatic test_st_half_wdelay();
      set_slave(0, 0, 3, 0, 1, '0, 2'd0);
      do_txn(2'd3, 2'd1, 32'h2002, 32'h0000_ABCD);
      n_chk++; if (o_awaddr !== 32'h2000) begin n_fail++; $display("FAIL sth_awaddr got %h exp 00002000", o_awaddr); end
      n_chk++; if (o_wdata !== 32'hABCD_0000) begin n_fail++; $display("FAIL sth_wdata got %h exp abcd0000", o_wdata); end
      n_chk++; if (o_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sth_wstrb got %b exp 1100", o_wstrb); end
      n_chk++; if (o_viol !== 0) begin n_fail++; $display("FAIL sth_handshake_rules got %0d violations exp 0", o_viol); end
      n_chk++; if (o_nresp !== 1 || o_err !== 2'd0 || o_rdata !== '0) begin n_fail++;
         $display("FAIL sth_resp got n=%0d err=%0d rdata=%h exp n=1 err=0 rdata=0", o_nresp, o_err, o_rdata); end
      n_chk++; if (o_lat !== 7) begin n_fail++; $display("FAIL sth_latency got %0d exp 7", o_lat); end
   endtask

   task automatic test_bus_error();
      set_slave(1, 0, 0, 2, 0, 32'h1234_5678, 2'b10);
      do_txn(2'd1, 2'd2, 32'h0100, '0);
      n_chk++; if (o_err !== 2'd1 || o_rdata !== '0) begin n_fail++;
         $display("FAIL rd_buserr got err=%0d rdata=%h exp err=1 rdata=0", o_err, o_rdata); end
      set_slave(0, 1, 0, 0, 2, '0, 2'b11);
      do_txn(2'd3, 2'd2, 32'h0104, 32'hCAFE_F00D);
      n_chk++; if (o_err !== 2'd1 || o_nresp !== 1) begin n_fail++;
         $display("FAIL wr_buserr got err=%0d n=%0d exp err=1 n=1", o_err, o_nresp); end
   endtask

   task automatic test_unsupported();
      set_slave(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2'd0);
      do_txn(2'd1, 2'd3, 32'h0200, '0);
      n_chk++; if (o_err !== 2'd3 || o_lat !== 1) begin n_fail++;
         $display("FAIL dbl_unsup got err=%0d lat=%0d exp err=3 lat=1", o_err, o_lat); end
      n_chk++; if (o_ar !== 1'b0 || o_rdata !== '0) begin n_fail++;
         $display("FAIL dbl_no_bus got ar=%b rdata=%h exp ar=0 rdata=0", o_ar, o_rdata); end
   endtask

   task automatic test_misalign();
      set_slave(0, 0, 0, 0, 0, 32'hA1B2_C3D4, 2'd0);
      model(2'd1, 2'd2, 32'h3001, '0, 32'hA1B2_C3D4, 2'd0);
      do_txn(2'd1, 2'd2, 32'h3001, '0);
      n_chk++; if (o_err !== e_err || o_rdata !== e_rdata) begin n_fail++;
         $display("FAIL mis_resp got err=%0d rdata=%h exp err=%0d rdata=%h", o_err, o_rdata, e_err, e_rdata); end
      n_chk++; if (o_ar !== (e_bus == 1) || o_lat !== ((e_bus == 0) ? 1 : 3)) begin n_fail++;
         $display("FAIL mis_bus got ar=%b lat=%0d exp ar=%b lat=%0d", o_ar, o_lat, e_bus == 1, (e_bus == 0) ? 1 : 3); end
      n_chk++; if (o_ar && o_araddr !== 32'h3000) begin n_fail++; $display("FAIL mis_araddr got %h exp 00003000", o_araddr); end
   endtask

   task automatic test_none();
      set_slave(0, 0, 0, 0, 0, '0, 2'd0);
      do_txn(2'd0, 2'd2, 32'h0400, 32'h1111_1111);
      n_chk++; if (o_nresp !== 0 || o_ar !== 1'b0 || o_aw !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
         $display("FAIL none_noop got n=%0d ar=%b aw=%b rdy=%b exp 0 0 0 1", o_nresp, o_ar, o_aw, req_ready); end
   endtask

   task automatic test_random();
      logic [1:0] f, sz, xr;
      logic [ADDR_W-1:0] a;
      logic [XLEN-1:0] wd, rd;
      for (int it = 0; it < 80; it++) begin
         f = 2'($urandom_range(1, 3)); sz = 2'($urandom_range(0, 3));
         a = $urandom; wd = XLEN'({$urandom, $urandom}); rd = XLEN'({$urandom, $urandom});
         xr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), rd, xr);
         model(f, sz, a, wd, rd, xr);
         do_txn(f, sz, a, wd);
         n_chk++; if (o_nresp !== 1 || o_err !== e_err || o_rdata !== e_rdata || o_viol !== 0) begin n_fail++;
            $display("FAIL rnd%0d_resp f=%0d sz=%0d a=%h got n=%0d err=%0d rdata=%h viol=%0d exp n=1 err=%0d rdata=%h viol=0",
                     it, f, sz, a, o_nresp, o_err, o_rdata, o_viol, e_err, e_rdata); end
         n_chk++; if (o_ar !== (e_bus == 1) || o_aw !== (e_bus == 2) || (e_bus == 0 && o_lat !== 1)) begin n_fail++;
            $display("FAIL rnd%0d_bus got ar=%b aw=%b lat=%0d exp bus=%0d", it, o_ar, o_aw, o_lat, e_bus); end
         if (e_bus == 1) begin
            n_chk++; if (o_araddr !== e_baddr) begin n_fail++; $display("FAIL rnd%0d_araddr got %h exp %h", it, o_araddr, e_baddr); end
         end
         if (e_bus == 2) begin
            n_chk++; if (o_awaddr !== e_baddr || o_wdata !== e_wdata || o_wstrb !== e_wstrb) begin n_fail++;
               $display("FAIL rnd%0d_wr got addr=%h data=%h strb=%b exp addr=%h data=%h strb=%b",
                        it, o_awaddr, o_wdata, o_wstrb, e_baddr, e_wdata, e_wstrb); end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int cyc, seen;
      req_valid = 1; req_funct = 2'd3; req_size = 2'd2; req_addr = 32'h0040; req_wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      req_valid = 0; awready = 1; wready = 1;
      @(posedge clk); #1;
      awready = 0; wready = 0;
      cyc = 0;
      while (!bready && cyc < 10) begin @(posedge clk); #1; cyc++; end
      n_chk++; if (bready !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wr_b got bready=%b exp 1", bready); end
      #2 rst_n = 0;
      #1;
      n_chk++; if ({awvalid, wvalid, bready, arvalid, resp_valid} !== 5'b0) begin n_fail++;
         $display("FAIL rstmid_async_drop got %b exp 00000", {awvalid, wvalid, bready, arvalid, resp_valid}); end
      @(negedge clk); rst_n = 1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      n_chk++; if (seen !== 0 || req_ready !== 1'b1) begin n_fail++;
         $display("FAIL rstmid_after got resp_pulses=%0d rdy=%b exp 0 1", seen, req_ready); end
   endtask

   initial begin
      req_valid = 0; req_funct = 2'd0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
      slave_idle();
      set_slave(0, 0, 0, 0, 0, '0, 2'd0);
      repeat (2) @(posedge clk);
      #1 test_reset();
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      test_reset();
      test_ld_byte_sign();
      test_st_half_wdelay();
      test_bus_error();
      test_unsupported();
      test_misalign();
      test_none();
      test_random();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/lsu_axi_fsm.md
Name: lsu_axi_fsm

Overview:
- Sequential successor to the combinational load/store unit. Takes one load/store request at a time from the core and runs a full AXI4-Lite transaction on independent AW/W/B and AR/R channels, with registered outputs and real valid/ready handshakes.
- Returns load data (byte-lane extracted, sign- or zero-extended) or store completion with a status code.
- Data width is parametrised (32/64), adding doubleword accesses. Sits between the execute stage and the data-side AXI4-Lite interconnect; the core stalls while req_ready is low.

Parameters:
XLEN, 32, data/bus width in bits; legal values 32 or 64. NBYTES = XLEN/8, OFFW = log2(NBYTES).
ADDR_W, 32, address width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
req_funct  in  2  0=NONE, 1=LD (sign-extend), 2=LDU (zero-extend), 3=ST
req_size  in  2  0=BYTE, 1=HALF, 2=WORD, 3=DOUBLE
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  one-cycle pulse, completion of the accepted request
resp_rdata  out  XLEN  load result; 0 on stores and errors
resp_err  out  2  0=OK, 1=bus error (xRESP!=OKAY), 2=misaligned, 3=unsupported size
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
wdata/wstrb/wvalid/wready  out/out/out/in  XLEN/NBYTES/1/1  write data channel
bresp/bvalid/bready  in/in/out  2/1/1  write response channel
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
rdata/rresp/rvalid/rready  in/in/in/out  XLEN/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - awvalid=wvalid=arvalid=0; bready=rready=0; addr/data/strb outputs=0.
  - Reset mid-transaction drops all valids immediately and abandons the transaction.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE:
  - Accepted request with funct=NONE: no-op, no response, stay IDLE.
  - Otherwise latch funct, size, addr, wdata, and the byte offset off=addr[OFFW-1:0].
  - size=DOUBLE with XLEN=32: err=3, go to RESP, no bus traffic.
  - Else LD/LDU go to RD_A; ST goes to WR_AW.
- Bus address: araddr/awaddr = addr with the low OFFW bits cleared, registered and stable while valid is high.
- Store lanes:
  - wdata = req_wdata << (8*off).
  - wstrb = ((1<<(1<<size))-1) << off, truncated to NBYTES bits.
- RD_A: arvalid=1 until arready is sampled high, then RD_D.
- RD_D:
  - rready=1.
  - On rvalid: extract (1<<size) bytes starting at lane off and extend per funct. WORD on XLEN=64 extends per funct; DOUBLE passes through.
  - err=1 if rresp!=0, with rdata forced to 0. Go to RESP.
- WR_AW:
  - awvalid and wvalid are both raised on entry and drop independently on their own handshakes (aw_done/w_done flags).
  - Both handshakes may complete in the same cycle or in either order.
  - Go to WR_B when both are done.
- WR_B: bready=1. On bvalid, err=1 if bresp!=0, else 0. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle with the registered rdata/err, then IDLE. req_ready is low in every state except IDLE.
- Latency (ready/valid tied high): request accepted at cycle 0, arvalid/awvalid high at cycle 1, R/B accepted at cycle 2, resp_valid at cycle 3. Error short paths give resp_valid at cycle 1.
- A valid is never deasserted before its handshake, and its payload never changes while valid is high.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- When defined: a request with off % (1<<size) != 0 issues no bus transaction and goes IDLE to RESP with err=2 and rdata=0 (resp_valid at cycle 1).
- When undefined: misaligned requests are issued normally. Strobes and lanes beyond NBYTES are truncated, and load bytes past the top lane read as 0 before extension.

Test Plan:
- XLEN=32, LD BYTE addr=0x1003, rdata=0x80FF_0000 -> araddr=0x1000, resp_rdata=0xFFFF_FF80, err=0, resp_valid at cycle 3.
- XLEN=32, ST HALF addr=0x2002, wdata=0x0000_ABCD -> awaddr=0x2000, wdata=0xABCD_0000, wstrb=4'b1100. With wready delayed 3 cycles after awready, both valids are held correctly and a single resp_valid is produced.
- XLEN=64, LDU WORD addr=0x8004, rdata=0xDEAD_BEEF_1234_5678 -> resp_rdata=0x0000_0000_DEAD_BEEF. Then ST DOUBLE -> wstrb=8'hFF.
- XLEN=32, LD WORD with rresp=2'b10 -> resp_err=1, resp_rdata=0. Separately, size=DOUBLE -> resp_err=3 at cycle 1 with arvalid never asserted.
- LSU_MISALIGN_TRAP_EN defined, LD WORD addr=0x3001 -> resp_err=2 at cycle 1, no AR traffic. Undefined -> arvalid asserted, araddr=0x3000.
- rst_n pulled low while WR_B waits on bvalid -> awvalid/wvalid/bready=0 asynchronously, req_ready=1 after release, no resp_valid.
